// File: rtl/vx_tc_rf_fetch.sv
// Tensor-core register-file fetch: reads up to MAX_REGS consecutive GPRs
// through the operand-stage side port and returns them as one response.
//
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   req_*             request handshake: base address, register count, tag
//   tc_rf_valid/addr  side-port read strobe and address (one per cycle)
//   tc_rf_data        side-port read data, valid one cycle after the strobe
//   rsp_*             response handshake: data slots, count, tag
//   busy              high whenever the engine is not idle
module vx_tc_rf_fetch #(
    parameter int NUM_THREADS = 4,
    parameter int XLEN        = 32,
    parameter int RAM_ADDRW   = 8,
    parameter int MAX_REGS    = 8,
    parameter int TAG_W       = 4,
    localparam int CNT_W      = $clog2(MAX_REGS + 1),
    localparam int DW         = NUM_THREADS * XLEN
) (
    input  logic                   clk,
    input  logic                   reset,

    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [RAM_ADDRW-1:0]   req_base_addr,
    input  logic [CNT_W-1:0]       req_count,
    input  logic [TAG_W-1:0]       req_tag,

    output logic                   tc_rf_valid,
    output logic [RAM_ADDRW-1:0]   tc_rf_addr,
    input  logic [DW-1:0]          tc_rf_data,

    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [MAX_REGS*DW-1:0] rsp_data,
    output logic [CNT_W-1:0]       rsp_count,
    output logic [TAG_W-1:0]       rsp_tag,

    output logic                   busy
);

    localparam int IDX_W = (MAX_REGS > 1) ? $clog2(MAX_REGS) : 1;
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_REGS);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t                       state;
    logic [RAM_ADDRW-1:0]         base;
    logic [IDX_W-1:0]             issue_idx;
    logic [IDX_W-1:0]             last_idx;
    logic                         rd_valid_d;
    logic [IDX_W-1:0]             rd_idx_d;
    logic [MAX_REGS-1:0][DW-1:0]  slots;

    logic [CNT_W-1:0]             eff_count;
    logic [IDX_W-1:0]             eff_last;

    // Requests asking for more than MAX_REGS are clamped, not rejected.
    always_comb begin
        eff_count = (req_count > MAX_CNT) ? MAX_CNT : req_count;
        eff_last  = IDX_W'(eff_count - CNT_W'(1));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            base       <= '0;
            issue_idx  <= '0;
            last_idx   <= '0;
            rd_valid_d <= 1'b0;
            rd_idx_d   <= '0;
            rsp_count  <= '0;
            rsp_tag    <= '0;
            slots      <= '0;
        end else begin
            // Read data trails the strobe by one cycle; the delayed
            // valid/index pair steers it into its slot.
            rd_valid_d <= (state == FETCH);
            rd_idx_d   <= issue_idx;
            if (rd_valid_d) begin
                slots[rd_idx_d] <= tc_rf_data;
            end

            unique case (state)
                IDLE: begin
                    if (req_valid) begin
                        base      <= req_base_addr;
                        rsp_tag   <= req_tag;
                        rsp_count <= eff_count;
                        last_idx  <= eff_last;
                        issue_idx <= '0;
                        slots     <= '0;
                        state     <= (eff_count != '0) ? FETCH : RESP;
                    end
                end
                FETCH: begin
                    issue_idx <= issue_idx + IDX_W'(1);
                    if (issue_idx == last_idx) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    // Final beat lands at the end of this cycle.
                    state <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign req_ready   = (state == IDLE);
    assign busy        = (state != IDLE);
    assign rsp_valid   = (state == RESP);
    assign tc_rf_valid = (state == FETCH);
    // Address wraps modulo 2^RAM_ADDRW; held at zero when idle.
    assign tc_rf_addr  = tc_rf_valid ? (base + RAM_ADDRW'(issue_idx)) : '0;
    assign rsp_data    = slots;

endmodule

// File: tb/tb_vx_tc_rf_fetch.sv
// Directed bench for vx_tc_rf_fetch with a 1-cycle-latency RF model.
// Ports: none (top-level testbench).
module tb_vx_tc_rf_fetch;

    logic          clk;
    logic          reset;
    logic          req_valid;
    logic          req_ready;
    logic [7:0]    req_base_addr;
    logic [3:0]    req_count;
    logic [3:0]    req_tag;
    logic          tc_rf_valid;
    logic [7:0]    tc_rf_addr;
    logic [127:0]  tc_rf_data;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [1023:0] rsp_data;
    logic [3:0]    rsp_count;
    logic [3:0]    rsp_tag;
    logic          busy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int bad_strobe = 0;
    logic [7:0] strobe_addr[$];
    int         strobe_cyc[$];

    vx_tc_rf_fetch dut (
        .clk(clk),
        .reset(reset),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_base_addr(req_base_addr),
        .req_count(req_count),
        .req_tag(req_tag),
        .tc_rf_valid(tc_rf_valid),
        .tc_rf_addr(tc_rf_addr),
        .tc_rf_data(tc_rf_data),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_data(rsp_data),
        .rsp_count(rsp_count),
        .rsp_tag(rsp_tag),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [127:0] rf_val(input logic [7:0] a);
        logic [127:0] r;
        for (int l = 0; l < 4; l++) begin
            r[l*32 +: 32] = {a, 8'(l + 1), 8'h3C, a ^ 8'(l * 17)};
        end
        return r;
    endfunction

    // RF model: data appears one cycle after the strobe, junk otherwise.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (tc_rf_valid) tc_rf_data <= rf_val(tc_rf_addr);
        else             tc_rf_data <= {4{32'hDEADBEEF}};
        if (!reset && tc_rf_valid) begin
            strobe_addr.push_back(tc_rf_addr);
            strobe_cyc.push_back(cyc);
        end
        if (!reset && tc_rf_valid && (!busy || rsp_valid)) bad_strobe <= bad_strobe + 1;
        if (!reset && !tc_rf_valid && tc_rf_addr != 8'h00) bad_strobe <= bad_strobe + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [1023:0] obs,
                       input logic [1023:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    task automatic run_req(input logic [7:0] b, input logic [3:0] c,
                           input logic [3:0] tg);
        int n;
        int t;
        int tr;
        logic [7:0] a;
        logic [1023:0] exp;
        n = (c > 4'd8) ? 8 : int'(c);
        strobe_addr.delete();
        strobe_cyc.delete();
        chk("req_ready_idle", req_ready, 1);
        req_base_addr = b;
        req_count     = c;
        req_tag       = tg;
        req_valid     = 1'b1;
        t = cyc;
        tick();
        req_valid = 1'b0;
        tr = -1;
        for (int i = 0; i < 40 && tr < 0; i++) begin
            if (rsp_valid) tr = cyc;
            else tick();
        end
        chk("rsp_latency", tr, (n == 0) ? t + 1 : t + n + 2);
        chk("strobe_count", strobe_addr.size(), n);
        for (int k = 0; k < n && k < strobe_addr.size(); k++) begin
            a = b + 8'(k);
            chk("strobe_addr", strobe_addr[k], a);
            chk("strobe_cycle", strobe_cyc[k], t + 1 + k);
        end
        exp = '0;
        for (int k = 0; k < n; k++) begin
            a = b + 8'(k);
            exp[k*128 +: 128] = rf_val(a);
        end
        chk("rsp_data", rsp_data, exp);
        chk("rsp_count", rsp_count, n);
        chk("rsp_tag", rsp_tag, tg);
        if (rsp_ready) begin
            tick();
            chk("idle_after_rsp", {rsp_valid, req_ready, busy}, 3'b010);
        end
    endtask

    initial begin
        logic [1023:0] snap;
        reset         = 1'b1;
        req_valid     = 1'b0;
        req_base_addr = '0;
        req_count     = '0;
        req_tag       = '0;
        rsp_ready     = 1'b1;
        tick();
        tick();
        tick();
        chk("rst_ctl", {req_ready, tc_rf_valid, rsp_valid, busy}, 4'b1000);
        chk("rst_addr", tc_rf_addr, 0);
        chk("rst_cnt_tag", {rsp_count, rsp_tag}, 0);
        chk("rst_data", rsp_data, 0);
        reset = 1'b0;
        tick();

        run_req(8'h10, 4'd3, 4'd5);
        run_req(8'hFE, 4'd4, 4'd9);
        run_req(8'h55, 4'd0, 4'd3);
        run_req(8'h80, 4'd12, 4'hC);

        // Response back-pressure.
        rsp_ready = 1'b0;
        run_req(8'h40, 4'd2, 4'd7);
        snap = rsp_data;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("stall_ctl", {rsp_valid, req_ready, busy, rsp_count, rsp_tag},
                {1'b1, 1'b0, 1'b1, 4'd2, 4'd7});
            chk("stall_data", rsp_data, snap);
        end
        rsp_ready = 1'b1;
        tick();
        chk("stall_release", {rsp_valid, req_ready, busy}, 3'b010);

        // Reset in the cycle after the second strobe.
        req_base_addr = 8'h20;
        req_count     = 4'd6;
        req_tag       = 4'd1;
        req_valid     = 1'b1;
        tick();
        req_valid = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mid_rst_ctl", {tc_rf_valid, rsp_valid, req_ready, busy}, 4'b0010);
        chk("mid_rst_data", rsp_data, 0);
        tick();
        chk("mid_rst_late_beat", rsp_data, 0);
        chk("mid_rst_no_rsp", {rsp_valid, tc_rf_valid}, 2'b00);
        run_req(8'h30, 4'd5, 4'd6);

        // Back-to-back pseudo-random requests.
        for (int i = 0; i < 8; i++) begin
            run_req(8'($urandom_range(0, 255)), 4'($urandom_range(0, 12)),
                    4'($urandom_range(0, 15)));
        end

        chk("strobe_outside_fetch", bad_strobe, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/vx_tc_rf_fetch.md
VX_TC_RF_FETCH -- requirements
Module: vx_tc_rf_fetch

Interface
REQ-001 SHALL have parameter NUM_THREADS, default 4, lanes per register read.
REQ-002 SHALL have parameter XLEN, default 32, bits per lane.
REQ-003 SHALL have parameter RAM_ADDRW, default 8, GPR bank address width ({wis, reg}).
REQ-004 SHALL have parameter MAX_REGS, default 8, registers per request; CNT_W = clog2(MAX_REGS+1).
REQ-005 SHALL have parameter TAG_W, default 4, opaque request tag width.
REQ-006 SHALL have port clk, input, 1, clock.
REQ-007 SHALL have port reset, input, 1, reset; synchronous, active-high.
REQ-008 SHALL have ports req_valid input 1 and req_ready output 1, request handshake.
REQ-009 SHALL have port req_base_addr, input, RAM_ADDRW, first GPR address.
REQ-010 SHALL have port req_count, input, CNT_W, number of consecutive registers.
REQ-011 SHALL have port req_tag, input, TAG_W, returned unchanged with the response.
REQ-012 SHALL have port tc_rf_valid, output, 1, side-port read strobe to the operand stage.
REQ-013 SHALL have port tc_rf_addr, output, RAM_ADDRW, side-port read address.
REQ-014 SHALL have port tc_rf_data, input, NUM_THREADS*XLEN, read data returned one cycle after the strobe.
REQ-015 SHALL have ports rsp_valid output 1 and rsp_ready input 1, response handshake.
REQ-016 SHALL have port rsp_data, output, MAX_REGS*NUM_THREADS*XLEN; slot k holds register base+k.
REQ-017 SHALL have ports rsp_count output CNT_W and rsp_tag output TAG_W.
REQ-018 SHALL have port busy, output, 1, high in any state other than IDLE.

Function
REQ-019 SHALL implement the FSM states IDLE, FETCH, DRAIN and RESP.
REQ-020 SHALL assert req_ready only in IDLE; a request fires on req_valid && req_ready.
REQ-021 On fire, SHALL latch base, tag and eff_count = min(req_count, MAX_REGS), zero all rsp_data slots, and clear issue_idx.
REQ-022 On fire, SHALL go to FETCH if eff_count > 0, else go directly to RESP with rsp_count = 0 and no strobe.
REQ-023 In FETCH, SHALL drive tc_rf_valid = 1 and tc_rf_addr = base + issue_idx, truncated to RAM_ADDRW bits (wraps modulo 2^RAM_ADDRW).
REQ-024 In FETCH, SHALL increment issue_idx every cycle and go to DRAIN after the cycle with issue_idx = eff_count-1.
REQ-025 tc_rf_valid SHALL be 0 in every state except FETCH, and tc_rf_addr SHALL be 0 when tc_rf_valid = 0.
REQ-026 SHALL register (tc_rf_valid, issue_idx) one cycle and write tc_rf_data into slot issue_idx_d when the delayed valid is 1.
REQ-027 DRAIN SHALL last exactly one cycle, capture the final beat, then go to RESP.
REQ-028 In RESP, SHALL hold rsp_valid = 1 and keep rsp_data, rsp_count and rsp_tag stable until rsp_ready, then go to IDLE.
REQ-029 Latency: with fire in cycle T and N = eff_count > 0, strobes occur in T+1..T+N and rsp_valid first rises in cycle T+N+2.
REQ-030 Slots with index >= eff_count SHALL read 0.
REQ-031 SHALL NOT accept a new request in the cycle rsp fires; back-to-back requests are separated by at least one IDLE cycle.
REQ-032 SHALL perform no writeback bypass; the requester guarantees that no write to the fetched registers is in flight.

Reset
REQ-033 While reset is high at a clock edge, SHALL enter IDLE and clear issue_idx, the delayed-valid register, rsp_count, rsp_tag and rsp_data.
REQ-034 Reset outputs SHALL be: req_ready = 1, tc_rf_valid = 0, tc_rf_addr = 0, rsp_valid = 0, busy = 0.
REQ-035 Reset during FETCH or DRAIN SHALL discard the partial response; a late tc_rf_data beat SHALL NOT be captured.

Verification
REQ-036 Base 0x10, count 3, tag 5: strobes 0x10, 0x11, 0x12 in cycles T+1..T+3; rsp_valid in T+5; slots 0..2 hold the model RF, slots 3..7 = 0; tag 5.
REQ-037 Base 0xFE, count 4: addresses 0xFE, 0xFF, 0x00, 0x01; data ordered by slot.
REQ-038 Count 0: no tc_rf_valid; rsp_valid in T+1 with rsp_count 0 and all slots 0. Count 12: clamped to 8 strobes, rsp_count 8.
REQ-039 Hold rsp_ready = 0 for 10 cycles: rsp_valid and outputs stay stable, req_ready = 0, busy = 1; rsp_ready = 1 returns to IDLE next cycle.
REQ-040 Assert reset in the cycle after the 2nd strobe of a count-6 request: tc_rf_valid = 0 next cycle, no rsp_valid, req_ready = 1; the next request completes correctly.
REQ-041 Random back-to-back requests against an RF model with 1-cycle read latency: every rsp_data matches the model and tc_rf_valid is never high outside FETCH.
